// File: rtl/bus_rbtr_rr_n.sv
// Shared-bus arbiter and packet router for drvrs driver FIFOs.
// Round-robin grant, one word per 3-cycle IDLE/POP/PUSH transfer, with broadcast and invalid-ID drop counting.
module bus_rbtr_rr_n #(
    parameter int               bits      = 32,
    parameter int               drvrs     = 8,
    parameter int               id_w      = 8,
    parameter logic [id_w-1:0]  broadcast = {id_w{1'b1}},
    localparam int              pw        = $clog2(drvrs)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [drvrs-1:0]        pndng,
    input  logic [drvrs*bits-1:0]   D_pop,
    output logic [drvrs-1:0]        pop,
    output logic [drvrs-1:0]        push,
    output logic [bits-1:0]         D_push,
    output logic                    bus_busy,
    output logic [15:0]             drop_cnt,
    output logic [1:0]              state_dbg,
    output logic [pw-1:0]           ptr_dbg
);

    // Handshake: pndng[i] is driver i's valid flag with show-ahead data on D_pop;
    // the one-cycle pop[i] strobe is the acknowledge, and the word is taken at the edge that ends it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_nx;
    logic [pw-1:0]       ptr_q;
    logic [pw-1:0]       ptr_nx;
    logic [pw-1:0]       grant_q;
    logic [pw-1:0]       grant_nx;
    logic                any_req;
    logic [drvrs-1:0]    pop_q;
    logic [drvrs-1:0]    push_q;
    logic [drvrs-1:0]    push_nx;
    logic [bits-1:0]     d_push_q;
    logic                busy_q;
    logic [15:0]         drop_q;
    logic                drop_nx;
    logic [bits-1:0]     cap_word;
    logic [id_w-1:0]     dest;

    // Round-robin scan starting at ptr, wrapping modulo drvrs.
    always_comb begin
        any_req  = 1'b0;
        grant_nx = grant_q;
        for (int i = 0; i < drvrs; i++) begin
            if (!any_req && pndng[(int'(ptr_q) + i) % drvrs]) begin
                any_req  = 1'b1;
                grant_nx = pw'((int'(ptr_q) + i) % drvrs);
            end
        end
    end

    assign cap_word = D_pop[int'(grant_q)*bits +: bits];
    assign dest     = cap_word[bits-1 -: id_w];
    assign ptr_nx   = (grant_q == pw'(drvrs - 1)) ? '0 : grant_q + 1'b1;

    // Destination decode; broadcast wins even if it aliases a valid driver index.
    always_comb begin
        push_nx = '0;
        drop_nx = 1'b0;
        if (dest == broadcast) begin
            push_nx          = '1;
            push_nx[grant_q] = 1'b0;
        end else if (int'(dest) < drvrs) begin
            push_nx = drvrs'(1) << dest;
        end else begin
            drop_nx = 1'b1;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (any_req) state_nx = POP;
            POP:     state_nx = PUSH;
            PUSH:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q    <= '0;
            grant_q  <= '0;
            pop_q    <= '0;
            push_q   <= '0;
            d_push_q <= '0;
            busy_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_nx;
                        pop_q   <= drvrs'(1) << grant_nx;
                        busy_q  <= 1'b1;
                    end
                end
                POP: begin
                    pop_q    <= '0;
                    d_push_q <= cap_word;
                    push_q   <= push_nx;
                    ptr_q    <= ptr_nx;
                    if (drop_nx && (drop_q != 16'hFFFF)) begin
                        drop_q <= drop_q + 16'd1;
                    end
                end
                PUSH: begin
                    push_q <= '0;
                    busy_q <= 1'b0;
                end
                default: begin
                    pop_q  <= '0;
                    push_q <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign pop       = pop_q;
    assign push      = push_q;
    assign D_push    = d_push_q;
    assign bus_busy  = busy_q;
    assign drop_cnt  = drop_q;
    assign state_dbg = state_q;
    assign ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_bus_rbtr_rr_n.sv
// Directed bench for bus_rbtr_rr_n: an 8-driver/32-bit instance and a 5-driver/16-bit instance.
module tb_bus_rbtr_rr_n;

    logic         clk = 1'b0;
    logic         reset;

    logic [7:0]   pndng;
    logic [255:0] d_pop;
    logic [7:0]   pop;
    logic [7:0]   push;
    logic [31:0]  d_push;
    logic         bus_busy;
    logic [15:0]  drop_cnt;
    logic [1:0]   state_dbg;
    logic [2:0]   ptr_dbg;

    logic [4:0]   pndng2;
    logic [79:0]  d_pop2;
    logic [4:0]   pop2;
    logic [4:0]   push2;
    logic [15:0]  d_push2;
    logic         bus_busy2;
    logic [15:0]  drop_cnt2;
    logic [1:0]   state_dbg2;
    logic [2:0]   ptr_dbg2;

    int n_assert = 0;
    int n_fail   = 0;

    bus_rbtr_rr_n #(.bits(32), .drvrs(8), .id_w(8), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop), .push(push),
        .D_push(d_push), .bus_busy(bus_busy), .drop_cnt(drop_cnt),
        .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
    );

    bus_rbtr_rr_n #(.bits(16), .drvrs(5), .id_w(4), .broadcast(4'hF)) dut2 (
        .clk(clk), .reset(reset), .pndng(pndng2), .D_pop(d_pop2), .pop(pop2), .push(push2),
        .D_push(d_push2), .bus_busy(bus_busy2), .drop_cnt(drop_cnt2),
        .state_dbg(state_dbg2), .ptr_dbg(ptr_dbg2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transfer on the 8-driver instance; pndng drops once the pop is seen.
    task automatic send1(input int src, input logic [31:0] w, input logic [7:0] exp_push,
                         input logic [15:0] exp_drop);
        d_pop[src*32 +: 32] = w;
        pndng = 8'b1 << src;
        tick();
        chk("pop_strobe", pop, 8'b1 << src);
        chk("push_in_pop", push, 8'h00);
        chk("busy_in_pop", bus_busy, 1'b1);
        pndng = 8'h00;
        tick();
        chk("push_mask", push, exp_push);
        chk("d_push_word", d_push, w);
        chk("pop_in_push", pop, 8'h00);
        chk("busy_in_push", bus_busy, 1'b1);
        tick();
        chk("push_after", push, 8'h00);
        chk("busy_after", bus_busy, 1'b0);
        chk("state_idle", state_dbg, 2'd0);
        chk("d_push_hold", d_push, w);
        chk("drop_cnt", drop_cnt, exp_drop);
    endtask

    task automatic send2(input int src, input logic [15:0] w, input logic [4:0] exp_push,
                         input logic [15:0] exp_drop);
        d_pop2[src*16 +: 16] = w;
        pndng2 = 5'b1 << src;
        tick();
        chk("p2_pop_strobe", pop2, 5'b1 << src);
        pndng2 = 5'b0;
        tick();
        chk("p2_push_mask", push2, exp_push);
        chk("p2_d_push", d_push2, w);
        tick();
        chk("p2_push_after", push2, 5'b0);
        chk("p2_drop_cnt", drop_cnt2, exp_drop);
    endtask

    initial begin
        reset  = 1'b0;
        pndng  = 8'h00;
        d_pop  = '0;
        pndng2 = 5'b0;
        d_pop2 = '0;
        tick();
        tick();
        chk("rst_pop", pop, 8'h00);
        chk("rst_push", push, 8'h00);
        chk("rst_d_push", d_push, 32'h0);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_drop", drop_cnt, 16'h0);
        chk("rst_state", state_dbg, 2'd0);
        chk("rst_ptr", ptr_dbg, 3'd0);
        chk("rst2_push", push2, 5'b0);
        chk("rst2_drop", drop_cnt2, 16'h0);
        reset = 1'b1;
        tick();

        // Unicast: driver 2 to driver 5.
        send1(2, 32'h0500ABCD, 8'h20, 16'h0);
        chk("ptr_after_uni", ptr_dbg, 3'd3);

        // Round robin from a fresh pointer: dest of driver i is 7-i.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) d_pop[i*32 +: 32] = {8'(7 - i), 24'hA00000 + 24'(i)};
        pndng = 8'hFF;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (c % 3 == 0) chk("rr_pop", pop, 8'b1 << (c / 3));
            else            chk("rr_pop_idle", pop, 8'h00);
            if (c % 3 == 1) begin
                chk("rr_push", push, 8'b1 << (7 - c / 3));
                chk("rr_d_push", d_push, {8'(7 - c / 3), 24'hA00000 + 24'(c / 3)});
            end
        end
        chk("rr_state_end", state_dbg, 2'd0);
        chk("rr_ptr_wrap", ptr_dbg, 3'd0);
        pndng = 8'hF0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (c % 3 == 0) chk("rr_upper_pop", pop, 8'b1 << (4 + (c / 3) % 4));
        end
        pndng = 8'h00;
        chk("rr_upper_ptr", ptr_dbg, 3'd5);

        // Broadcast from driver 3.
        send1(3, 32'hFF123456, 8'hF7, 16'h0);

        // Invalid destination 9 from driver 1.
        send1(1, 32'h09000001, 8'h00, 16'h1);

        // Saturation: preload the counter, then drop again.
        force dut.drop_q = 16'hFFFF;
        #1;
        release dut.drop_q;
        chk("sat_preload", drop_cnt, 16'hFFFF);
        send1(1, 32'h09000002, 8'h00, 16'hFFFF);

        // Reset during POP of a unicast from driver 6.
        d_pop[6*32 +: 32] = 32'h02000077;
        pndng = 8'h40;
        tick();
        chk("mid_pop", pop, 8'h40);
        reset = 1'b0;
        tick();
        chk("mid_rst_pop", pop, 8'h00);
        chk("mid_rst_push", push, 8'h00);
        chk("mid_rst_d_push", d_push, 32'h0);
        chk("mid_rst_drop", drop_cnt, 16'h0);
        chk("mid_rst_state", state_dbg, 2'd0);
        chk("mid_rst_ptr", ptr_dbg, 3'd0);
        chk("mid_rst_busy", bus_busy, 1'b0);
        reset = 1'b1;
        pndng = 8'h00;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid_quiet_push", push, 8'h00);
            chk("mid_quiet_pop", pop, 8'h00);
        end

        // Narrow instance: driver 4 sends dest 0, broadcast, then invalid dest 5.
        send2(4, 16'h0123, 5'b00001, 16'h0);
        chk("p2_ptr_wrap", ptr_dbg2, 3'd0);
        send2(4, 16'hF456, 5'b01111, 16'h0);
        send2(4, 16'h5789, 5'b00000, 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_rbtr_rr_n.md
# bus_rbtr_rr_n

Parametrised N-driver shared-bus arbiter and packet router. Each cycle it samples the pending flags of all driver FIFOs, grants one driver in round-robin order, pops one word, and pushes it onto the shared bus to the addressed driver, or to all other drivers on broadcast. It replaces the fixed 5-driver bus generator/arbiter wrapper with flattened vector ports, fair arbitration, and invalid-destination drop accounting.

## Interface
- bits, 32: packet word width; must be greater than id_w.
- drvrs, 8: number of drivers; range 2..255.
- id_w, 8: destination-ID field width, located at D_pop word bits [bits-1 -: id_w].
- broadcast, {8{1'b1}}: ID value meaning "all drivers except source"; width id_w.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- pndng  in  drvrs  bit i high: driver i FIFO holds a word; show-ahead data is on D_pop.
- D_pop  in  drvrs*bits  driver i word at [i*bits +: bits].
- pop  out  drvrs  one-hot, one-cycle pop strobe to driver i.
- push  out  drvrs  push strobe to driver i; multi-hot on broadcast.
- D_push  out  bits  shared bus word, common to all drivers.
- bus_busy  out  1  high in states POP and PUSH.
- drop_cnt  out  16  saturating count of dropped invalid-destination packets.

## Operation
- FSM states: IDLE, POP, PUSH.
  - **IDLE:** if any pndng bit is high, register `grant` = first index j with pndng[j]=1, scanning ptr, ptr+1, … modulo drvrs. Then go to POP. Otherwise stay in IDLE.
  - **POP:** pop[grant]=1 for exactly this cycle. Capture D_pop[grant] into the bus register, decode `dest` from the captured word, set ptr = (grant+1) mod drvrs, then go to PUSH.
  - **PUSH:** D_push = captured word. Drive push from `dest`:
    - dest == broadcast: push = all ones with bit grant cleared.
    - dest < drvrs: push = one-hot(dest). A self-addressed packet (dest == grant) is delivered to the source.
    - otherwise (invalid): push = 0 and drop_cnt increments, saturating at 16'hFFFF.
  - After PUSH, go to IDLE.
- Round-robin pointer `ptr` resets to 0. It advances only on a grant, so a driver that was just granted has lowest priority next round.
- pop, push and bus_busy are registered outputs. push is high only in PUSH; pop is high only in POP.
- D_push holds its last value outside PUSH.
- pndng changes during POP or PUSH have no effect. The new state is sampled in the next IDLE.
- A broadcast ID below drvrs is a configuration error; broadcast takes precedence.

## Timing
- Reset values (reset=0 at a rising edge): state IDLE, ptr 0, pop 0, push 0, D_push 0, bus_busy 0, drop_cnt 0.
- Per-packet latency and throughput:
  - pndng sampled high at edge k (state IDLE).
  - pop high in cycle k+1.
  - push and D_push valid in cycle k+2.
  - Back in IDLE at k+3.
  - Maximum throughput: 1 packet per 3 cycles.
- Driver FIFOs must present valid show-ahead data while pndng=1. The word is sampled at the same edge that ends the pop strobe.
- Reset asserted in POP or PUSH aborts the transfer: no push is issued and the captured word is discarded. If pop was already high in that cycle, the word is lost (accepted behaviour).
- drvrs=1-hot width rules: pop and push are exactly drvrs bits. The ID compare is unsigned on id_w bits.

## Test plan
- **Unicast (drvrs=8):** after reset, pndng=8'h04 with D_pop[2]=32'h05_00ABCD, held until popped.
  - Required: pop=8'h04 in cycle k+1; push=8'h20 and D_push=32'h05_00ABCD in cycle k+2.
  - Required: bus_busy high exactly in those 2 cycles.
- **Round-robin fairness:** pndng=8'hFF held for 24 cycles, all destinations valid.
  - Required: grant order 0,1,2,…,7 with exactly one pop every 3 cycles.
  - Then clear bits 0–3 and keep 4–7 pending: order continues from ptr (0 wraps to first pending ≥ ptr).
- **Broadcast:** driver 3 word 32'hFF_123456.
  - Required: push=8'hF7 and D_push=32'hFF_123456 for one cycle; drop_cnt unchanged.
- **Invalid destination:** driver 1 word with ID 8'h09 (drvrs=8).
  - Required: pop[1] pulses, push stays 0 throughout, drop_cnt goes 0→1.
  - Preload saturation by forcing 16'hFFFF: drop_cnt stays 16'hFFFF after another drop.
- **Reset mid-operation:** assert reset in the POP cycle of a unicast.
  - Required: next cycle pop=0, push=0, D_push=0, drop_cnt=0, state IDLE, ptr=0.
  - No push appears afterwards without a new pndng.
- **Parametrisation (drvrs=5, bits=16, id_w=4, broadcast=4'hF):** driver 4 sends dest 0, then dest 4'hF.
  - Required: push=5'b00001, then push=5'b01111 with matching D_push.
  - Required: dest 4'h5 is dropped.
